nds_rr_arb_oh: RTL and testbench



---
 rtl/nds_rr_arb_oh.sv | 95 +++++++++
 tb/tb_nds_rr_arb_oh.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/nds_rr_arb_oh.sv
// Round-robin arbiter with registered one-hot grant and binary index.
// Grant holds until accepted; priority then rotates past the winner.
module nds_rr_arb_oh #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant_oh,
    output logic [W-1:0] grant_idx,
    output logic         grant_valid,
    input  logic         grant_ready,
    output logic [N-1:0] ack
);

    logic [N-1:0] gnt_q;
    logic [W-1:0] idx_q;
    logic         valid_q;
    logic [N-1:0] prio_ptr;

    logic         load;
    logic         accept;
    logic [N-1:0] eff_req;
    logic [N-1:0] rot_gnt;
    logic [N-1:0] arb_ptr;
    logic [N-1:0] upper;
    logic [N-1:0] next_gnt;
    logic [W-1:0] next_idx;

    function automatic logic [W-1:0] oh2bin(input logic [N-1:0] oh);
        logic [W-1:0] b;
        b = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) b = b | W'(i);
        end
        return b;
    endfunction

    // Grant state: IDLE is gnt_q==0, HOLD is gnt_q!=0 awaiting ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_q    <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            prio_ptr <= N'(1);
        end else if (load) begin
            gnt_q   <= next_gnt;
            idx_q   <= next_idx;
            valid_q <= |next_gnt;
            if (accept) prio_ptr <= rot_gnt;
        end
    end

    // Next grant: first eligible request at or above the pointer, else wrap.
    always_comb begin
        load    = ~valid_q | grant_ready;
        accept  = valid_q & grant_ready;
        eff_req = req & ~(gnt_q & {N{grant_ready}});
        rot_gnt = {gnt_q[N-2:0], gnt_q[N-1]};
        arb_ptr = accept ? rot_gnt : prio_ptr;
        upper   = eff_req & ~(arb_ptr - N'(1));
        if (|upper) begin
            next_gnt = upper & (~upper + N'(1));
        end else begin
            next_gnt = eff_req & (~eff_req + N'(1));
        end
        next_idx = oh2bin(next_gnt);
    end

    // Outputs: registered grant view plus combinational accept pulse.
    always_comb begin
        grant_oh    = gnt_q;
        grant_idx   = idx_q;
        grant_valid = valid_q;
        ack         = gnt_q & {N{grant_ready}};
    end

    a_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(grant_oh))
        else $error("grant_oh not one-hot");

    a_idx: assert property (@(posedge clk) disable iff (!reset_n)
        grant_idx == oh2bin(grant_oh))
        else $error("grant_idx does not match grant_oh");

    a_hold: assert property (@(posedge clk) disable iff (!reset_n)
        (grant_valid && !grant_ready) |=> $stable(grant_oh))
        else $error("grant changed while holding");

    a_req: assert property (@(posedge clk) disable iff (!reset_n)
        (grant_oh & ~req & ~ack) == '0)
        else $error("granted request dropped before ack");

endmodule

// File: tb/tb_nds_rr_arb_oh.sv
// Bench for nds_rr_arb_oh (N=4): directed table, reset corner,
// then random traffic checked against an index-based round-robin model.
module tb_nds_rr_arb_oh;

    localparam int N = 4;

    logic         clk;
    logic         reset_n;
    logic [N-1:0] req;
    logic [N-1:0] grant_oh;
    logic [1:0]   grant_idx;
    logic         grant_valid;
    logic         grant_ready;
    logic [N-1:0] ack;

    int n_vec;
    int n_err;

    int m_g;
    int m_ptr;

    typedef struct {
        logic [3:0] r;
        logic       rd;
        logic [3:0] oh;
        logic [1:0] idx;
        logic       v;
        logic [3:0] ak;
    } vec_t;

    vec_t tv[27];

    nds_rr_arb_oh #(.N(N)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req),
        .grant_oh(grant_oh),
        .grant_idx(grant_idx),
        .grant_valid(grant_valid),
        .grant_ready(grant_ready),
        .ack(ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] eoh,
                       input logic [1:0] eidx, input logic ev,
                       input logic [3:0] eak);
        n_vec++;
        if (grant_oh !== eoh || grant_idx !== eidx ||
            grant_valid !== ev || ack !== eak) begin
            n_err++;
            $display("FAIL %s: got oh=%b idx=%0d v=%b ack=%b want oh=%b idx=%0d v=%b ack=%b",
                     nm, grant_oh, grant_idx, grant_valid, ack,
                     eoh, eidx, ev, eak);
        end
    endtask

    task automatic model_reset();
        m_g   = -1;
        m_ptr = 0;
    endtask

    // Reference: grant holder as an integer, pointer as an integer.
    task automatic model_step(input logic [3:0] r, input logic rd);
        logic [3:0] e;
        int start;
        int k;
        e = r;
        start = m_ptr;
        if (m_g >= 0 && !rd) return;
        if (m_g >= 0 && rd) begin
            e[m_g] = 1'b0;
            start = (m_g + 1) % N;
            m_ptr = start;
        end
        m_g = -1;
        for (int j = 0; j < N; j++) begin
            k = (start + j) % N;
            if (e[k] && m_g < 0) m_g = k;
        end
    endtask

    // Apply inputs, check at the falling edge, then clock once.
    task automatic cyc(input string nm, input logic [3:0] r, input logic rd,
                       input logic [3:0] eoh, input logic [1:0] eidx,
                       input logic ev, input logic [3:0] eak);
        req = r;
        grant_ready = rd;
        @(negedge clk);
        chk(nm, eoh, eidx, ev, eak);
        @(posedge clk);
        #1;
        model_step(r, rd);
    endtask

    initial begin
        logic [3:0] pend;
        logic [3:0] eoh;
        logic [3:0] r;
        logic       rd;
        n_vec = 0;
        n_err = 0;
        model_reset();

        tv[0]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000};
        tv[1]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000};
        tv[2]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000};
        tv[3]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000};
        tv[4]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000};
        tv[5]  = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000};
        tv[6]  = '{4'b1110, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001};
        tv[7]  = '{4'b1101, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010};
        tv[8]  = '{4'b1011, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100};
        tv[9]  = '{4'b0111, 1'b1, 4'b1000, 2'd3, 1'b1, 4'b1000};
        tv[10] = '{4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001};
        tv[11] = '{4'b0110, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000};
        tv[12] = '{4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000};
        tv[13] = '{4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000};
        tv[14] = '{4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000};
        tv[15] = '{4'b0110, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010};
        tv[16] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100};
        tv[17] = '{4'b1000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000};
        tv[18] = '{4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, 4'b1000};
        tv[19] = '{4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000};
        tv[20] = '{4'b1001, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001};
        tv[21] = '{4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, 4'b1000};
        tv[22] = '{4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000};
        tv[23] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100};
        tv[24] = '{4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000};
        tv[25] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100};
        tv[26] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000};

        reset_n = 1'b0;
        req = '0;
        grant_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 27; i++) begin
            cyc($sformatf("tv%0d", i), tv[i].r, tv[i].rd,
                tv[i].oh, tv[i].idx, tv[i].v, tv[i].ak);
        end

        cyc("rst_pre0", 4'b0110, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000);
        cyc("rst_pre1", 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000);
        #2;
        reset_n = 1'b0;
        grant_ready = 1'b1;
        #1;
        chk("rst_async", 4'b0000, 2'd0, 1'b0, 4'b0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        grant_ready = 1'b0;
        req = 4'b0110;
        model_reset();
        @(posedge clk);
        #1;
        model_step(4'b0110, 1'b0);
        cyc("rst_post0", 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000);
        cyc("rst_post1", 4'b0110, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010);

        pend = 4'b0100;
        for (int c = 0; c < 500; c++) begin
            r  = pend;
            rd = 1'($urandom_range(0, 3) != 0);
            eoh = (m_g >= 0) ? 4'(1 << m_g) : 4'b0000;
            cyc($sformatf("rnd%0d", c), r, rd, eoh,
                (m_g >= 0) ? 2'(m_g) : 2'd0, m_g >= 0,
                rd ? eoh : 4'b0000);
            if (rd) pend = pend & ~eoh;
            pend = pend | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
